// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants, word/ID types and the incrementer result payload.
package cpu_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned ID_W   = 3;

  localparam logic DIR_INC = 1'b1;
  localparam logic DIR_DEC = 1'b0;

  localparam logic [WORD_W-1:0] WORD_MAX = 16'hFFFF;
  localparam logic [WORD_W-1:0] WORD_MIN = 16'h0000;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ID_W-1:0]   id_t;

  typedef struct packed {
    logic  valid;
    id_t   id;
    word_t data;
    logic  wrap;
  } inc_res_t;

  // True when a +1/-1 step on v crosses the word boundary.
  function automatic logic wraps(input word_t v, input logic dir);
    return ((dir == DIR_INC) && (v == WORD_MAX)) ||
           ((dir == DIR_DEC) && (v == WORD_MIN));
  endfunction

endpackage

// File: rtl/incrementer.sv
// Shared 16-bit +1/-1 unit; result is modulo 2^16.
module incrementer
  import cpu_pkg::*;
(
  input  word_t i_in,
  input  logic  i_dir,
  output word_t o_out
);

  assign o_out = (i_dir == DIR_INC) ? (i_in + word_t'(1)) : (i_in - word_t'(1));

endmodule

// File: rtl/inc_arbiter.sv
// Arbitrates NREQ requesters onto one shared incrementer and registers the
// winning result with consumer back-pressure.
module inc_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned PRIO0 = 0
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NREQ-1:0]        i_req,
  input  logic [NREQ*WORD_W-1:0] i_val,
  input  logic [NREQ-1:0]        i_dir,
  input  logic                   i_hold,
  output logic [NREQ-1:0]        o_gnt,
  output logic                   o_valid,
  output logic [ID_W-1:0]        o_id,
  output logic [WORD_W-1:0]      o_out,
  output logic                   o_wrap
);

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] gnt;
  logic            win_found;
  logic            prio_win;
  id_t             win_id;
  id_t             rr_ptr;
  id_t             rr_ptr_nxt;
  logic            accept;
  word_t           sel_val;
  logic            sel_dir;
  word_t           inc_out;
  inc_res_t        res_q;
  inc_res_t        res_d;

  // Requester 0 leaves the round-robin group when it has fixed priority.
  always_comb begin
    elig = i_req;
    if (PRIO0 != 0) begin
      elig[0] = 1'b0;
    end
  end

  // Winner select: priority requester first, then scan from rr_ptr upward
  // (pass 1), wrapping to the low indices below rr_ptr (pass 2).
  always_comb begin
    win_found = 1'b0;
    prio_win  = 1'b0;
    win_id    = '0;
    if ((PRIO0 != 0) && i_req[0]) begin
      win_found = 1'b1;
      prio_win  = 1'b1;
    end else begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        if (!win_found && elig[k] && (id_t'(k) >= rr_ptr)) begin
          win_found = 1'b1;
          win_id    = id_t'(k);
        end
      end
      for (int unsigned k = 0; k < NREQ; k++) begin
        if (!win_found && elig[k]) begin
          win_found = 1'b1;
          win_id    = id_t'(k);
        end
      end
    end
  end

  assign accept = (|i_req) && !(res_q.valid && i_hold);

  // One-hot grant, suppressed while reset is asserted.
  always_comb begin
    gnt = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      gnt[k] = i_rst_n && accept && win_found && (win_id == id_t'(k));
    end
  end

  assign o_gnt = gnt;

  // Operand mux steered by the winner index.
  always_comb begin
    sel_val = '0;
    sel_dir = DIR_INC;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (win_id == id_t'(k)) begin
        sel_val = i_val[k*WORD_W +: WORD_W];
        sel_dir = i_dir[k];
      end
    end
  end

  incrementer u_inc (
    .i_in  (sel_val),
    .i_dir (sel_dir),
    .o_out (inc_out)
  );

  // Pointer moves past each round-robin winner; priority wins leave it alone.
  always_comb begin
    rr_ptr_nxt = rr_ptr;
    if (accept && win_found && !prio_win) begin
      rr_ptr_nxt = (win_id == id_t'(NREQ-1)) ? id_t'(0) : (win_id + id_t'(1));
    end
  end

  // Output register: capture on accept, drain when idle, freeze on stall.
  always_comb begin
    res_d = res_q;
    if (accept) begin
      res_d.valid = 1'b1;
      res_d.id    = win_id;
      res_d.data  = inc_out;
      res_d.wrap  = wraps(sel_val, sel_dir);
    end else if (!(res_q.valid && i_hold)) begin
      res_d.valid = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      res_q  <= '0;
      rr_ptr <= '0;
    end else begin
      res_q  <= res_d;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  assign o_valid = res_q.valid;
  assign o_id    = res_q.id;
  assign o_out   = res_q.data;
  assign o_wrap  = res_q.wrap;

endmodule

// File: tb/tb_inc_arbiter.sv
// Directed bench for inc_arbiter: one round-robin instance and one with
// requester 0 at fixed priority, both driven from the same stimulus.
module tb_inc_arbiter;

  localparam int unsigned NREQ = 4;

  logic             clk;
  logic             rst_n;
  logic [NREQ-1:0]  req;
  logic [NREQ*16-1:0] val;
  logic [NREQ-1:0]  dir;
  logic             hold;

  logic [NREQ-1:0]  gnt_rr, gnt_pr;
  logic             valid_rr, valid_pr;
  logic [2:0]       id_rr, id_pr;
  logic [15:0]      out_rr, out_pr;
  logic             wrap_rr, wrap_pr;

  int checks;
  int failures;

  inc_arbiter #(.NREQ(NREQ), .PRIO0(0)) u_dut_rr (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_req   (req),
    .i_val   (val),
    .i_dir   (dir),
    .i_hold  (hold),
    .o_gnt   (gnt_rr),
    .o_valid (valid_rr),
    .o_id    (id_rr),
    .o_out   (out_rr),
    .o_wrap  (wrap_rr)
  );

  inc_arbiter #(.NREQ(NREQ), .PRIO0(1)) u_dut_pr (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_req   (req),
    .i_val   (val),
    .i_dir   (dir),
    .i_hold  (hold),
    .o_gnt   (gnt_pr),
    .o_valid (valid_pr),
    .o_id    (id_pr),
    .o_out   (out_pr),
    .o_wrap  (wrap_pr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int k, input logic [15:0] v, input logic d);
    val[k*16 +: 16] = v;
    dir[k]          = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    hold  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Expected grant sequence for the fixed-priority instance.
  int pr_req[6]  = '{4'b1110, 4'b1110, 4'b1111, 4'b1111, 4'b1110, 4'b1110};
  int pr_win[6]  = '{1, 2, 0, 0, 3, 1};

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    req      = 4'b1111;
    val      = '0;
    dir      = '1;
    hold     = 1'b0;

    // Reset with all requesters asserted
    tick();
    tick();
    check("rst_gnt_rr", 32'(gnt_rr), 32'h0);
    check("rst_gnt_pr", 32'(gnt_pr), 32'h0);
    check("rst_valid", 32'(valid_rr), 32'h0);
    check("rst_out", 32'(out_rr), 32'h0);
    check("rst_id", 32'(id_rr), 32'h0);
    rst_n = 1'b1;
    #1;
    check("rel_gnt", 32'(gnt_rr), 32'h1);
    tick();
    check("rel_id", 32'(id_rr), 32'h0);
    check("rel_valid", 32'(valid_rr), 32'h1);
    check("rel_out", 32'(out_rr), 32'h0001);

    // Single request
    do_reset();
    set_op(2, 16'h0115, 1'b1);
    req = 4'b0100;
    #1;
    check("single_gnt", 32'(gnt_rr), 32'h4);
    tick();
    req = 4'b0000;
    check("single_valid", 32'(valid_rr), 32'h1);
    check("single_id", 32'(id_rr), 32'h2);
    check("single_out", 32'(out_rr), 32'h0116);
    check("single_wrap", 32'(wrap_rr), 32'h0);

    // Wrap at both boundaries, back to back, then drain
    do_reset();
    set_op(1, 16'hFFFF, 1'b1);
    set_op(3, 16'h0000, 1'b0);
    req = 4'b0010;
    #1;
    check("wrap_up_gnt", 32'(gnt_rr), 32'h2);
    tick();
    check("wrap_up_out", 32'(out_rr), 32'h0000);
    check("wrap_up_flag", 32'(wrap_rr), 32'h1);
    check("wrap_up_id", 32'(id_rr), 32'h1);
    req = 4'b1000;
    tick();
    check("wrap_dn_out", 32'(out_rr), 32'hFFFF);
    check("wrap_dn_flag", 32'(wrap_rr), 32'h1);
    check("wrap_dn_id", 32'(id_rr), 32'h3);
    check("wrap_dn_valid", 32'(valid_rr), 32'h1);
    req = 4'b0000;
    tick();
    check("drain_valid", 32'(valid_rr), 32'h0);
    check("drain_out_kept", 32'(out_rr), 32'hFFFF);
    check("drain_id_kept", 32'(id_rr), 32'h3);

    // Round-robin with all four requesting
    do_reset();
    for (int k = 0; k < 4; k++) set_op(k, 16'(k) << 8, 1'b1);
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("rr_gnt%0d", i), 32'(gnt_rr), 32'(1 << (i % 4)));
      tick();
      check($sformatf("rr_id%0d", i), 32'(id_rr), 32'(i % 4));
      check($sformatf("rr_valid%0d", i), 32'(valid_rr), 32'h1);
      check($sformatf("rr_out%0d", i), 32'(out_rr), 32'(((i % 4) << 8) + 1));
    end

    // Fixed priority for requester 0, round-robin resumes after it drops
    do_reset();
    for (int i = 0; i < 6; i++) begin
      req = 4'(pr_req[i]);
      #1;
      check($sformatf("pr_gnt%0d", i), 32'(gnt_pr), 32'(1 << pr_win[i]));
      tick();
      check($sformatf("pr_id%0d", i), 32'(id_pr), 32'(pr_win[i]));
    end

    // Stall holds the result and blocks grants; release grants same cycle
    do_reset();
    set_op(0, 16'h0041, 1'b0);
    req = 4'b0001;
    #1;
    check("stall_first_gnt", 32'(gnt_rr), 32'h1);
    tick();
    check("stall_first_out", 32'(out_rr), 32'h0040);
    set_op(0, 16'h0100, 1'b1);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("stall_gnt_rr%0d", i), 32'(gnt_rr), 32'h0);
      check($sformatf("stall_gnt_pr%0d", i), 32'(gnt_pr), 32'h0);
      tick();
      check($sformatf("stall_out_rr%0d", i), 32'(out_rr), 32'h0040);
      check($sformatf("stall_out_pr%0d", i), 32'(out_pr), 32'h0040);
      check($sformatf("stall_valid%0d", i), 32'(valid_rr), 32'h1);
    end
    hold = 1'b0;
    #1;
    check("unstall_gnt", 32'(gnt_rr), 32'h1);
    tick();
    check("unstall_out", 32'(out_rr), 32'h0101);
    check("unstall_id", 32'(id_rr), 32'h0);

    // Hold with no valid result is ignored
    req = 4'b0000;
    tick();
    hold = 1'b1;
    set_op(2, 16'h1234, 1'b0);
    req = 4'b0100;
    #1;
    check("hold_idle_gnt", 32'(gnt_rr), 32'h4);
    tick();
    check("hold_idle_out", 32'(out_rr), 32'h1233);
    hold = 1'b0;
    req  = 4'b0000;

    // Reset mid-operation drops the pending result
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(valid_rr), 32'h0);
    check("midrst_out", 32'(out_rr), 32'h0);
    rst_n = 1'b1;
    tick();
    check("midrst_after", 32'(valid_rr), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inc_arbiter.md
Name: inc_arbiter

Overview:
- Shares the single 16-bit incrementer datapath between up to NREQ requesters (PC advance, SP push/pop, loop counter).
- Each requester presents a value and a direction. The arbiter grants one requester per cycle and drives its operands into the incrementer.
- It registers the result, requester ID and wrap flag for one cycle, with consumer back-pressure.
- It sits between the register-file/sequencer logic and the incrementer instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- PRIO0, 0, 1 = requester 0 has fixed highest priority over the round-robin group; 0 = all requesters round-robin.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_req  input  NREQ  per-requester request; held high until granted.
- i_val  input  NREQ*16  flattened operands; requester k occupies bits [16k +: 16].
- i_dir  input  NREQ  per-requester direction: 1 = +1, 0 = -1.
- i_hold  input  1  consumer stall; freezes the output register while it holds valid data.
- o_gnt  output  NREQ  one-hot grant, combinational, in the capture cycle.
- o_valid  output  1  registered result valid.
- o_id  output  3  index of the requester that owns o_out.
- o_out  output  16  registered incrementer result.
- o_wrap  output  1  result wrapped (0xFFFF+1 -> 0x0000, or 0x0000-1 -> 0xFFFF).

Behaviour:
- Reset (i_rst_n low, asynchronous): o_valid=0, o_id=0, o_out=0x0000, o_wrap=0, RR pointer=0. o_gnt is forced to 0 while reset is low. Reset asserted mid-operation drops any pending result; nothing is replayed.
- Accept condition: accept = (|i_req) && !(o_valid && i_hold). When accept=0, o_gnt=0.
- Arbitration, applied when accept=1:
  - If PRIO0=1 and i_req[0] is high, requester 0 wins.
  - Otherwise the winner is the first requester with i_req high, scanning from the RR pointer upward modulo NREQ. When PRIO0=1, requester 0 is excluded from this RR scan.
  - o_gnt[winner]=1.
- Datapath: winner's i_val and i_dir are muxed combinationally into the incrementer. The result is mod 2^16.
- Capture edge (accept=1):
  - o_out <= incrementer output; o_id <= winner; o_valid <= 1.
  - o_wrap <= (dir=1 && val==0xFFFF) || (dir=0 && val==0x0000).
  - RR pointer <= winner+1 mod NREQ. The pointer is not advanced when PRIO0 wins with requester 0.
- Latency: exactly 1 cycle from grant to o_valid.
- Throughput: one result per cycle while i_hold=0.
- Stall:
  - If o_valid=1 and i_hold=1, the output registers and the RR pointer hold and no grant is issued.
  - If o_valid=0, i_hold is ignored; a grant may proceed.
- Drain: if accept=0 and !(o_valid && i_hold), o_valid <= 0 on the next edge. o_out, o_id and o_wrap keep their last values.
- Requester rules:
  - A requester observing o_gnt[k]=1 is served in that cycle. It deasserts i_req[k] or presents a new operand the next cycle.
  - Operands of an ungranted requester must stay stable.
- Simultaneous requests: at most one grant per cycle. With NREQ=4 and all four requesting continuously, grants rotate 0,1,2,3,0...
- Unused o_id bits (NREQ<8) are zero.

Decomposition:
- Shared package (cpu_pkg):
  - WORD_W=16.
  - DIR_INC=1'b1 and DIR_DEC=1'b0.
  - ID_W=3.
  - Wrap-boundary constants WORD_MAX=16'hFFFF and WORD_MIN=16'h0000.
- Sub-module: exactly one instance of the existing incrementer (ports i_in, i_dir, o_out). Arbitration, operand mux and output registers stay in inc_arbiter.

Test Plan:
- Reset: hold i_rst_n=0 with i_req=4'b1111 -> o_gnt=0, o_valid=0, o_out=0x0000. Release reset; next edge -> o_id=0, o_valid=1.
- Single request: i_req=4'b0100, val2=0x0115, dir2=1 -> o_gnt=4'b0100 same cycle; next cycle o_valid=1, o_id=2, o_out=0x0116, o_wrap=0.
- Wrap: val1=0xFFFF dir=1 -> o_out=0x0000, o_wrap=1. val3=0x0000 dir=0 -> o_out=0xFFFF, o_wrap=1.
- Round-robin: i_req=4'b1111 for 8 cycles, PRIO0=0 -> o_id sequence 0,1,2,3,0,1,2,3 with no gap in o_valid.
- Priority: PRIO0=1, i_req=4'b1110 then req0 also raised -> requester 0 granted every cycle it requests. When req0 drops, RR resumes at the requester after the last RR winner.
- Stall: result valid (val=0x0041, dir=0 -> 0x0040), i_hold=1 for 3 cycles with i_req high -> o_gnt=0 and o_out stays 0x0040. i_hold=0 -> next grant issues the same cycle.
